// File: rtl/qracc_bitserial_mac.sv
// -----------------------------------------------------------------------------
// qracc_bitserial_mac
//
// Bit-serial charge-domain MAC model. A weight array mem[numRows][numCols]
// (one bit per cell, 1 = +1, 0 = -1) is multiplied by a vector of signed
// inBits-wide inputs. Each input bit-plane is applied in one cycle, LSB first.
// The per-column matched bit-line (MBL) sum is range-shifted, quantised to a
// signed numAdcBits ADC code and shift-accumulated. The MSB plane is
// subtracted, which gives two's-complement input weighting.
//
// Ports
//   CLK, nRESET            clock, asynchronous active-low reset
//   WR_EN/WR_ADDR/WR_DATA  weight row write (honoured only while idle)
//   WR_ERR                 one-cycle pulse for a write dropped while busy
//   RD_EN/RD_ADDR/RD_DATA  registered weight row read (holds when RD_EN=0)
//   IN_VALID/IN_READY      start handshake; IN_READY is high exactly when idle
//   IN_VEC                 row r input at [r*inBits +: inBits]
//   OUT_VALID/OUT_READY    result handshake
//   ACC_OUT                column c result at [c*accBits +: accBits]
//   SAT_FLAG               per-column sticky ADC saturation
// -----------------------------------------------------------------------------
module qracc_bitserial_mac #(
  parameter int numRows       = 128,
  parameter int numCols       = 8,
  parameter int numAdcBits    = 4,
  parameter int inBits        = 4,
  parameter int adcRangeShift = 0,
  parameter int accBits       = 16
) (
  input  logic                           CLK,
  input  logic                           nRESET,
  input  logic                           WR_EN,
  input  logic [$clog2(numRows)-1:0]     WR_ADDR,
  input  logic [numCols-1:0]             WR_DATA,
  input  logic                           RD_EN,
  input  logic [$clog2(numRows)-1:0]     RD_ADDR,
  output logic [numCols-1:0]             RD_DATA,
  output logic                           WR_ERR,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  input  logic [numRows*inBits-1:0]      IN_VEC,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [numCols*accBits-1:0]     ACC_OUT,
  output logic [numCols-1:0]             SAT_FLAG
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int              KW     = (inBits > 1) ? $clog2(inBits) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(inBits - 1);

  // MBL spans [-numRows, numRows]; keep it wide enough to also hold the ADC limits.
  localparam int MW0 = $clog2(numRows) + 2;
  localparam int MW  = (MW0 > numAdcBits + 1) ? MW0 : numAdcBits + 1;
  localparam logic signed [MW-1:0] Q_MAX   = MW'((1 << (numAdcBits - 1)) - 1);
  localparam logic signed [MW-1:0] Q_MIN   = ~Q_MAX;  // -(Q_MAX) - 1
  localparam logic signed [MW-1:0] MBL_POS = MW'(1);
  localparam logic signed [MW-1:0] MBL_NEG = {MW{1'b1}};

  logic [numCols-1:0]        r_mem [numRows];
  logic [1:0]                r_state;
  logic [KW-1:0]             r_k;
  logic [numRows*inBits-1:0] r_in_vec;
  logic signed [accBits-1:0] r_acc [numCols];
  logic [numCols-1:0]        r_sat;
  logic [numCols-1:0]        r_rd_data;
  logic                      r_wr_err;

  logic                      w_idle;
  logic [numRows-1:0]        w_plane;
  logic signed [accBits-1:0] w_term [numCols];
  logic [numCols-1:0]        w_sat_hit;

  assign w_idle = (r_state == ST_IDLE);

  // NOTE: the weight array has no reset on purpose: weights must survive nRESET,
  // and a reset-free array can map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (WR_EN && w_idle) r_mem[WR_ADDR] <= WR_DATA;
  end

  // Non-blocking read of the same array returns the pre-write data on a collision.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)    r_rd_data <= '0;
    else if (RD_EN) r_rd_data <= r_mem[RD_ADDR];
  end

  // Current input bit-plane, one bit per row.
  always_comb begin
    for (int r = 0; r < numRows; r++) w_plane[r] = r_in_vec[r*inBits + int'(r_k)];
  end

  // NOTE: combinational logic uses blocking assignments and gives every output a
  // default before any conditional update, so no latch can be inferred.
  always_comb begin
    for (int c = 0; c < numCols; c++) begin
      logic signed [MW-1:0] v_mbl;
      logic signed [MW-1:0] v_q;
      v_mbl = '0;
      for (int r = 0; r < numRows; r++) begin
        if (w_plane[r]) v_mbl = v_mbl + (r_mem[r][c] ? MBL_POS : MBL_NEG);
      end
      v_q          = v_mbl >>> adcRangeShift;  // arithmetic: floor for negatives
      w_sat_hit[c] = 1'b0;
      if (v_q > Q_MAX) begin
        v_q          = Q_MAX;
        w_sat_hit[c] = 1'b1;
      end else if (v_q < Q_MIN) begin
        v_q          = Q_MIN;
        w_sat_hit[c] = 1'b1;
      end
      w_term[c] = accBits'(v_q) <<< r_k;  // signed cast sign-extends the ADC code
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_in_vec <= '0;
      r_sat    <= '0;
      r_wr_err <= 1'b0;
      for (int c = 0; c < numCols; c++) r_acc[c] <= '0;
    end else begin
      r_wr_err <= WR_EN && !w_idle;
      case (r_state)
        ST_IDLE: begin
          if (IN_VALID) begin
            r_in_vec <= IN_VEC;
            r_k      <= '0;
            r_sat    <= '0;
            for (int c = 0; c < numCols; c++) r_acc[c] <= '0;
            r_state  <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          // MSB plane carries negative weight in two's complement.
          for (int c = 0; c < numCols; c++) begin
            r_acc[c] <= (r_k == K_LAST) ? r_acc[c] - w_term[c] : r_acc[c] + w_term[c];
          end
          r_sat <= r_sat | w_sat_hit;
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_state <= ST_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_DONE: begin
          if (OUT_READY) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < numCols; c++) begin : g_acc_out
    assign ACC_OUT[c*accBits +: accBits] = r_acc[c];
  end

  assign IN_READY  = w_idle;
  assign OUT_VALID = (r_state == ST_DONE);
  assign SAT_FLAG  = r_sat;
  assign RD_DATA   = r_rd_data;
  assign WR_ERR    = r_wr_err;

endmodule

// File: tb/tb_qracc_bitserial_mac.sv
// -----------------------------------------------------------------------------
// tb_qracc_bitserial_mac
//
// Directed bench for qracc_bitserial_mac with numRows=8, numCols=2. Two DUTs
// share all inputs: u_a uses adcRangeShift=0, u_b uses adcRangeShift=1.
// Expected results come from an integer reference model and are queued when a
// start is issued, then popped when OUT_VALID is seen.
// -----------------------------------------------------------------------------
module tb_qracc_bitserial_mac;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        WR_EN = 1'b0;
  logic [2:0]  WR_ADDR = '0;
  logic [1:0]  WR_DATA = '0;
  logic        RD_EN = 1'b0;
  logic [2:0]  RD_ADDR = '0;
  logic        IN_VALID = 1'b0;
  logic [31:0] IN_VEC = '0;
  logic        OUT_READY = 1'b0;

  logic [1:0]  a_rd_data, b_rd_data, a_sat, b_sat;
  logic        a_wr_err, b_wr_err, a_in_ready, b_in_ready, a_out_valid, b_out_valid;
  logic [31:0] a_acc, b_acc;

  qracc_bitserial_mac #(.numRows(8), .numCols(2), .numAdcBits(4), .inBits(4),
                        .adcRangeShift(0), .accBits(16)) u_a (
    .CLK(CLK), .nRESET(nRESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(a_rd_data), .WR_ERR(a_wr_err),
    .IN_VALID(IN_VALID), .IN_READY(a_in_ready), .IN_VEC(IN_VEC),
    .OUT_VALID(a_out_valid), .OUT_READY(OUT_READY), .ACC_OUT(a_acc), .SAT_FLAG(a_sat));

  qracc_bitserial_mac #(.numRows(8), .numCols(2), .numAdcBits(4), .inBits(4),
                        .adcRangeShift(1), .accBits(16)) u_b (
    .CLK(CLK), .nRESET(nRESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(b_rd_data), .WR_ERR(b_wr_err),
    .IN_VALID(IN_VALID), .IN_READY(b_in_ready), .IN_VEC(IN_VEC),
    .OUT_VALID(b_out_valid), .OUT_READY(OUT_READY), .ACC_OUT(b_acc), .SAT_FLAG(b_sat));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    int         a0, a1, b0, b1;
    logic [1:0] asat, bsat;
  } exp_t;

  exp_t     sb[$];
  bit [1:0] tb_mem [8];
  int       tb_in  [8];
  int       total = 0;
  int       bad   = 0;
  int       t_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: signed inputs bit-serial against +/-1 weights, floor shift, clamp.
  function automatic void model_col(input int c, input int sh, output int acc, output bit sat);
    int mbl, q;
    acc = 0;
    sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mbl = 0;
      for (int r = 0; r < 8; r++) if (tb_in[r][k]) mbl += tb_mem[r][c] ? 1 : -1;
      q = mbl >>> sh;
      if (q > 7)  begin q = 7;  sat = 1'b1; end
      if (q < -8) begin q = -8; sat = 1'b1; end
      if (k == 3) acc -= q * (1 << k);
      else        acc += q * (1 << k);
    end
  endfunction

  function automatic exp_t model();
    exp_t e;
    bit s0, s1, s2, s3;
    model_col(0, 0, e.a0, s0);
    model_col(1, 0, e.a1, s1);
    model_col(0, 1, e.b0, s2);
    model_col(1, 1, e.b1, s3);
    e.asat = {s1, s0};
    e.bsat = {s3, s2};
    return e;
  endfunction

  task automatic wr(input int a, input bit [1:0] d);
    WR_EN = 1'b1; WR_ADDR = 3'(a); WR_DATA = d;
    tick();
    WR_EN = 1'b0;
    tb_mem[a] = d;
  endtask

  task automatic rd_check(input string tag, input int a);
    RD_EN = 1'b1; RD_ADDR = 3'(a);
    tick();
    RD_EN = 1'b0;
    check(tag, {30'h0, a_rd_data}, {30'h0, tb_mem[a]});
  endtask

  // Drives IN_VEC from tb_in, queues the model result, accepts on one edge.
  // Any WR_EN set up by the caller rides the same edge and is then released.
  task automatic start();
    for (int r = 0; r < 8; r++) IN_VEC[r*4 +: 4] = tb_in[r][3:0];
    sb.push_back(model());
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    WR_EN    = 1'b0;
    t_acc    = cyc;
    check("busy_in_ready", {31'h0, a_in_ready}, 32'h0);
  endtask

  task automatic wait_check();
    int   n;
    exp_t e;
    n = 0;
    while (a_out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("latency", 32'(cyc - t_acc), 32'd4);
    e = sb.pop_front();
    check("a_acc0", {16'h0, a_acc[15:0]},  {16'h0, e.a0[15:0]});
    check("a_acc1", {16'h0, a_acc[31:16]}, {16'h0, e.a1[15:0]});
    check("a_sat",  {30'h0, a_sat},        {30'h0, e.asat});
    check("b_acc0", {16'h0, b_acc[15:0]},  {16'h0, e.b0[15:0]});
    check("b_acc1", {16'h0, b_acc[31:16]}, {16'h0, e.b1[15:0]});
    check("b_sat",  {30'h0, b_sat},        {30'h0, e.bsat});
  endtask

  task automatic accept();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("accept_out_valid", {31'h0, a_out_valid}, 32'h0);
    check("accept_in_ready",  {31'h0, a_in_ready},  32'h1);
  endtask

  initial begin
    logic [31:0] held;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_in_ready",  {30'h0, b_in_ready, a_in_ready},   32'h3);
    check("rst_out_valid", {30'h0, b_out_valid, a_out_valid}, 32'h0);
    check("rst_acc",       a_acc | b_acc,                      32'h0);
    check("rst_sat",       {28'h0, b_sat, a_sat},              32'h0);
    check("rst_rd_data",   {28'h0, b_rd_data, a_rd_data},      32'h0);
    check("rst_wr_err",    {30'h0, b_wr_err, a_wr_err},        32'h0);
    nRESET = 1'b1;
    tick();

    // Weights: col0 = +1, col1 = -1 on every row
    for (int r = 0; r < 8; r++) wr(r, 2'b01);
    rd_check("rd_row3", 3);
    RD_ADDR = 3'd0;
    tick();
    check("rd_hold", {30'h0, a_rd_data}, 32'h1);

    // Every input = +1: only plane 0 active, col0 clamps 8 -> 7
    for (int r = 0; r < 8; r++) tb_in[r] = 1;
    start();
    wait_check();
    check("ones_col0", {16'h0, a_acc[15:0]},  32'h0007);
    check("ones_col1", {16'h0, a_acc[31:16]}, 32'hFFF8);
    check("ones_sat",  {30'h0, a_sat},        32'h1);

    // DONE holds and ignores IN_VALID while OUT_READY stays low
    held     = a_acc;
    IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_acc",       a_acc, held);
      check("hold_in_ready",  {31'h0, a_in_ready},  32'h0);
      check("hold_out_valid", {31'h0, a_out_valid}, 32'h1);
    end
    IN_VALID = 1'b0;
    accept();

    // Rows 0-2 = -1: mbl 3 per plane; write dropped during COMPUTE
    for (int r = 0; r < 8; r++) tb_in[r] = (r < 3) ? 15 : 0;
    start();
    WR_EN = 1'b1; WR_ADDR = 3'd5; WR_DATA = 2'b10;
    tick();
    check("wr_err_pulse", {30'h0, b_wr_err, a_wr_err}, 32'h3);
    WR_EN = 1'b0;
    tick();
    check("wr_err_clear", {31'h0, a_wr_err}, 32'h0);
    wait_check();
    check("neg_col0_sh0", {16'h0, a_acc[15:0]}, 32'hFFFD);
    check("neg_col0_sh1", {16'h0, b_acc[15:0]}, 32'hFFFF);
    check("neg_sat",      {30'h0, a_sat},       32'h0);
    accept();
    rd_check("dropped_write", 5);

    // Reset at k=2 abandons the operation and keeps the weights
    for (int r = 0; r < 8; r++) tb_in[r] = 7 + r;
    start();
    tick();
    tick();
    #2 nRESET = 1'b0;
    #1;
    check("abort_in_ready",  {31'h0, a_in_ready},  32'h1);
    check("abort_out_valid", {31'h0, a_out_valid}, 32'h0);
    check("abort_acc",       a_acc | b_acc,        32'h0);
    void'(sb.pop_back());
    tick();
    #2 nRESET = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_out", {31'h0, a_out_valid}, 32'h0);
    end
    rd_check("post_rst_row5", 5);
    rd_check("post_rst_row0", 0);

    // Mixed weights; read/write collision returns the old row
    for (int r = 0; r < 8; r++) wr(r, {r[0], r[1]});
    WR_EN = 1'b1; WR_ADDR = 3'd6; WR_DATA = 2'b11;
    RD_EN = 1'b1; RD_ADDR = 3'd6;
    tick();
    WR_EN = 1'b0; RD_EN = 1'b0;
    check("rw_old_data", {30'h0, a_rd_data}, {30'h0, tb_mem[6]});
    tb_mem[6] = 2'b11;
    rd_check("rw_new_data", 6);

    // Start with a simultaneous write: the write lands before plane 0
    for (int r = 0; r < 8; r++) tb_in[r] = int'($urandom_range(0, 15));
    WR_EN = 1'b1; WR_ADDR = 3'd7; WR_DATA = 2'b10;
    tb_mem[7] = 2'b10;
    start();
    check("start_wr_no_err", {31'h0, a_wr_err}, 32'h0);
    wait_check();
    accept();
    rd_check("start_wr_row7", 7);

    // MSB plane only (-8) against col0 all +1: clamps and subtracts
    for (int r = 0; r < 8; r++) wr(r, 2'b01);
    for (int r = 0; r < 8; r++) tb_in[r] = 8;
    start();
    wait_check();
    accept();

    // Random patterns
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < 8; r++) wr(r, 2'($urandom_range(0, 3)));
      for (int r = 0; r < 8; r++) tb_in[r] = int'($urandom_range(0, 15));
      start();
      wait_check();
      accept();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qracc_bitserial_mac.md
QRACC_BITSERIAL_MAC -- requirements
Module: qracc_bitserial_mac

Interface
REQ-001 SHALL have parameters: numRows 128, number of wordline rows; numCols 8, number of columns; numAdcBits 4, signed ADC code width; inBits 4, signed input precision; adcRangeShift 0, right-shift applied to the MBL value before quantisation; accBits 16, accumulator width, at least numAdcBits+inBits.
REQ-002 SHALL have ports: CLK in 1 clock; nRESET in 1 asynchronous active-low reset.
REQ-003 SHALL have ports: WR_EN in 1 write strobe; WR_ADDR in clog2(numRows) row address; WR_DATA in numCols weight bits.
REQ-004 SHALL have ports: RD_EN in 1 read strobe; RD_ADDR in clog2(numRows) row address; RD_DATA out numCols registered read data; WR_ERR out 1 dropped-write pulse.
REQ-005 SHALL have ports: IN_VALID in 1 start request; IN_READY out 1 idle; IN_VEC in numRows*inBits signed inputs, row r at [r*inBits +: inBits].
REQ-006 SHALL have ports: OUT_VALID out 1 result valid; OUT_READY in 1 result accept; ACC_OUT out numCols*accBits signed results, column c at [c*accBits +: accBits]; SAT_FLAG out numCols per-column ADC saturation.

Function
REQ-007 SHALL hold weight memory mem[numRows][numCols]; a write SHALL occur at a CLK edge only when WR_EN=1 and state=IDLE.
REQ-008 WR_EN=1 outside IDLE SHALL drop the write and pulse WR_ERR high for exactly one cycle.
REQ-009 RD_EN=1 SHALL load RD_DATA from mem[RD_ADDR] at the same edge; read and write to the same address in one cycle SHALL return the old data; RD_DATA SHALL hold when RD_EN=0.
REQ-010 SHALL implement states IDLE, COMPUTE, DONE; IN_READY SHALL be high exactly when state=IDLE.
REQ-011 IDLE with IN_VALID=1 at an edge SHALL latch IN_VEC, clear all accumulators and SAT_FLAG, set plane counter k=0, and move to COMPUTE; a simultaneous WR_EN SHALL still be honoured.
REQ-012 COMPUTE SHALL process one input bit-plane per edge, LSB first, for k=0..inBits-1.
REQ-013 For plane k and column c, mbl SHALL equal the sum over rows r with input bit k =1 of +1 if mem[r][c]=1, else -1; rows whose input bit is 0 SHALL contribute 0.
REQ-014 q SHALL equal mbl arithmetically right-shifted by adcRangeShift (floor), saturated to the range [-2^(numAdcBits-1), 2^(numAdcBits-1)-1]; saturation SHALL set SAT_FLAG[c] sticky until the next start.
REQ-015 acc[c] SHALL receive q sign-extended and shifted left by k, added for k<inBits-1 and subtracted for k=inBits-1 (two's-complement MSB); wrap in accBits is legal only if accBits is misconfigured.
REQ-016 After the edge that processes k=inBits-1, state SHALL become DONE with OUT_VALID=1; total latency SHALL be inBits edges after acceptance.
REQ-017 In DONE, ACC_OUT and SAT_FLAG SHALL hold stable; OUT_READY=1 at an edge SHALL return to IDLE and clear OUT_VALID; IN_VALID SHALL be ignored outside IDLE.
REQ-018 ACC_OUT SHALL show the running accumulators during COMPUTE; consumers SHALL sample it only with OUT_VALID=1.

Reset
REQ-019 nRESET=0 SHALL asynchronously force IDLE, k=0, ACC_OUT=0, SAT_FLAG=0, OUT_VALID=0, RD_DATA=0, WR_ERR=0, IN_READY=1 while asserted and after release.
REQ-020 Reset SHALL NOT alter mem contents; reset during COMPUTE or DONE SHALL abandon the operation with no output.

Verification (numRows=8, numCols=2, numAdcBits=4, inBits=4, accBits=16, adcRangeShift=0 unless stated)
REQ-021 Reset -> outputs all 0, IN_READY=1.
REQ-022 mem col0=1, col1=0 on all rows; every input=1 -> OUT_VALID 4 edges after acceptance; ACC_OUT col0=7, col1=-8; SAT_FLAG=2'b01.
REQ-023 col0=1 on all rows; rows 0-2 input=-1, others 0 -> col0 acc=-3, no saturation; with adcRangeShift=1 -> per-plane q=1, col0 acc=-1.
REQ-024 Hold OUT_READY=0 for 5 cycles in DONE with IN_VALID=1 -> ACC_OUT stable, IN_READY=0, no new start; OUT_READY=1 -> IDLE next edge.
REQ-025 WR_EN during COMPUTE -> WR_ERR one-cycle pulse; subsequent read of that address returns the prior data.
REQ-026 nRESET low at k=2 -> IDLE immediately, ACC_OUT=0; after release, a read returns the pre-reset weights.
